// File: rtl/mem_data_register.sv
// Memory data register: captures bus read data once per memory phase, extracts loads, flags misalignment.
// Result lands one edge after the last waitrequest-low cycle; stall holds the CPU while the bus waits.
module mem_data_register #(
    parameter int unsigned STATE_WIDTH = 3,
    parameter int unsigned MEM_STATE   = 3,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STATE_WIDTH-1:0] state,
    input  logic [2:0]             load_op,
    input  logic [1:0]             byte_addr,
    input  logic [31:0]            rt_data,
    input  logic [31:0]            mem_readdata,
    input  logic                   mem_waitrequest,
    output logic [31:0]            dr_readdata,
    output logic                   dr_valid,
    output logic                   stall,
    output logic                   addr_error
);

    localparam logic [STATE_WIDTH-1:0] MEM_ST = STATE_WIDTH'(MEM_STATE);

    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LWL = 3'd5;
    localparam logic [2:0] OP_LWR = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        in_mem;
    logic        capture;
    logic        misaligned;
    logic [31:0] extracted;
    logic [15:0] lane;
    logic [4:0]  lwl_sh;
    logic [4:0]  lwr_sh;

    assign in_mem = (state == MEM_ST);
    assign stall  = in_mem & mem_waitrequest & (fsm_q != S_DONE);

    // Byte/half lane selected by the address; 3-k equals ~k for a 2-bit k.
    assign lane   = 16'(mem_readdata >> {byte_addr, 3'b000});
    assign lwl_sh = {~byte_addr, 3'b000};
    assign lwr_sh = {byte_addr, 3'b000};

    always_comb begin
        extracted  = mem_readdata;
        misaligned = 1'b0;
        case (load_op)
            OP_LB:  extracted = {{24{lane[7]}}, lane[7:0]};
            OP_LBU: extracted = {24'h0, lane[7:0]};
            OP_LH: begin
                extracted  = {{16{lane[15]}}, lane[15:0]};
                misaligned = byte_addr[0];
            end
            OP_LHU: begin
                extracted  = {16'h0, lane[15:0]};
                misaligned = byte_addr[0];
            end
            OP_LWL: extracted = (mem_readdata << lwl_sh) | (rt_data & ((32'h1 << lwl_sh) - 32'h1));
            OP_LWR: extracted = (mem_readdata >> lwr_sh) | (rt_data & ~(32'hFFFF_FFFF >> lwr_sh));
            default: begin
                extracted  = mem_readdata;
                misaligned = (byte_addr != 2'b00);
            end
        endcase
    end

    always_comb begin
        fsm_d   = fsm_q;
        capture = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (in_mem) begin
                    if (mem_waitrequest) begin
                        fsm_d = S_WAIT;
                    end else begin
                        capture = 1'b1;
                        fsm_d   = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                // Leaving the memory state mid-wait abandons the access.
                if (!in_mem) begin
                    fsm_d = S_IDLE;
                end else if (!mem_waitrequest) begin
                    capture = 1'b1;
                    fsm_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (!in_mem) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (capture) begin
            if (misaligned) begin
                err_d = 1'b1;
            end else begin
                data_d  = extracted;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= S_IDLE;
            data_q  <= RESET_VALUE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign dr_readdata = data_q;
    assign dr_valid    = valid_q;
    assign addr_error  = err_q;

endmodule

// File: tb/tb_mem_data_register.sv
// Directed bench for mem_data_register: vector table for extraction, hand sequences for wait/abort/reset.
module tb_mem_data_register;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  state;
    logic [2:0]  load_op;
    logic [1:0]  byte_addr;
    logic [31:0] rt_data;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic [31:0] dr_readdata;
    logic        dr_valid;
    logic        stall;
    logic        addr_error;

    always #5 clk = ~clk;

    mem_data_register #(
        .STATE_WIDTH(3),
        .MEM_STATE(3),
        .RESET_VALUE(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .state(state),
        .load_op(load_op),
        .byte_addr(byte_addr),
        .rt_data(rt_data),
        .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest),
        .dr_readdata(dr_readdata),
        .dr_valid(dr_valid),
        .stall(stall),
        .addr_error(addr_error)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  ba;
        logic [31:0] rt;
        logic [31:0] mem;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] hold;

    initial begin
        vecs[0]  = '{3'd2, 2'd2, 32'h1122_3344, 32'h8899_AABB, 32'h0000_0099, 1'b0};
        vecs[1]  = '{3'd3, 2'd2, 32'h1122_3344, 32'h8899_AABB, 32'hFFFF_8899, 1'b0};
        vecs[2]  = '{3'd4, 2'd0, 32'h1122_3344, 32'h8899_AABB, 32'h0000_AABB, 1'b0};
        vecs[3]  = '{3'd3, 2'd0, 32'h1122_3344, 32'h8899_AABB, 32'hFFFF_AABB, 1'b0};
        vecs[4]  = '{3'd1, 2'd3, 32'h1122_3344, 32'h8899_AABB, 32'hFFFF_FF88, 1'b0};
        vecs[5]  = '{3'd1, 2'd1, 32'h1122_3344, 32'h8899_2ABB, 32'h0000_002A, 1'b0};
        vecs[6]  = '{3'd5, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344, 1'b0};
        vecs[7]  = '{3'd6, 2'd2, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB, 1'b0};
        vecs[8]  = '{3'd5, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0};
        vecs[9]  = '{3'd5, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 32'hDD22_3344, 1'b0};
        vecs[10] = '{3'd6, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0};
        vecs[11] = '{3'd6, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_33AA, 1'b0};
        vecs[12] = '{3'd7, 2'd0, 32'h1122_3344, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
        vecs[13] = '{3'd3, 2'd1, 32'h1122_3344, 32'h5555_6666, 32'h0000_0000, 1'b1};
        vecs[14] = '{3'd0, 2'd2, 32'h1122_3344, 32'h7777_8888, 32'h0000_0000, 1'b1};
        vecs[15] = '{3'd4, 2'd3, 32'h1122_3344, 32'h9999_AAAA, 32'h0000_0000, 1'b1};
        vecs[16] = '{3'd7, 2'd1, 32'h1122_3344, 32'hBBBB_CCCC, 32'h0000_0000, 1'b1};

        reset = 1'b1; state = 3'd0; load_op = 3'd0; byte_addr = 2'd0;
        rt_data = 32'h0; mem_readdata = 32'h0; mem_waitrequest = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_data", dr_readdata, 32'h0);
        check("reset_valid", {31'h0, dr_valid}, 32'h0);
        check("reset_err", {31'h0, addr_error}, 32'h0);
        check("reset_stall", {31'h0, stall}, 32'h0);

        // Load DEADBEEF, then reset with state idle.
        state = 3'd3; mem_readdata = 32'hDEAD_BEEF;
        tick();
        check("preload_data", dr_readdata, 32'hDEAD_BEEF);
        state = 3'd0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset2_data", dr_readdata, 32'h0);
        check("reset2_valid", {31'h0, dr_valid}, 32'h0);

        // LW, no wait; then hold the memory state with changing bus data.
        state = 3'd3; load_op = 3'd0; byte_addr = 2'd0; mem_readdata = 32'h1234_5678;
        tick();
        check("lw_data", dr_readdata, 32'h1234_5678);
        check("lw_valid", {31'h0, dr_valid}, 32'h1);
        mem_readdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lw_hold_valid", {31'h0, dr_valid}, 32'h0);
            check("lw_hold_data", dr_readdata, 32'h1234_5678);
        end
        state = 3'd0;
        tick();

        // Vector table: one capture per entry, then a cycle out of the memory state.
        hold = 32'h1234_5678;
        for (int v = 0; v < NVEC; v++) begin
            state = 3'd3; load_op = vecs[v].op; byte_addr = vecs[v].ba;
            rt_data = vecs[v].rt; mem_readdata = vecs[v].mem; mem_waitrequest = 1'b0;
            tick();
            if (!vecs[v].err) hold = vecs[v].exp;
            check($sformatf("vec%0d_data", v), dr_readdata, hold);
            check($sformatf("vec%0d_valid", v), {31'h0, dr_valid}, {31'h0, !vecs[v].err});
            check($sformatf("vec%0d_err", v), {31'h0, addr_error}, {31'h0, vecs[v].err});
            state = 3'd0;
            tick();
            check($sformatf("vec%0d_err_pulse", v), {31'h0, addr_error}, 32'h0);
        end

        // Wait-states: three stalled cycles with junk on the bus, then valid data.
        state = 3'd3; load_op = 3'd1; byte_addr = 2'd0;
        mem_readdata = 32'h1234_5601; mem_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait_stall", {31'h0, stall}, 32'h1);
            check("wait_novalid", {31'h0, dr_valid}, 32'h0);
            tick();
        end
        mem_waitrequest = 1'b0; mem_readdata = 32'h0000_00F0;
        #1;
        check("wait_release_stall", {31'h0, stall}, 32'h0);
        tick();
        check("wait_data", dr_readdata, 32'hFFFF_FFF0);
        check("wait_valid", {31'h0, dr_valid}, 32'h1);
        mem_waitrequest = 1'b1;
        #1;
        check("done_nostall", {31'h0, stall}, 32'h0);
        tick();
        check("wait_valid_once", {31'h0, dr_valid}, 32'h0);
        state = 3'd0; mem_waitrequest = 1'b0;
        tick();

        // Abort: leave the memory state during WAIT; no capture, next phase captures afresh.
        state = 3'd3; load_op = 3'd0; mem_readdata = 32'h5A5A_5A5A; mem_waitrequest = 1'b1;
        tick();
        state = 3'd0; mem_waitrequest = 1'b0;
        tick();
        check("abort_valid", {31'h0, dr_valid}, 32'h0);
        check("abort_data", dr_readdata, 32'hFFFF_FFF0);
        state = 3'd3;
        tick();
        check("after_abort_valid", {31'h0, dr_valid}, 32'h1);
        check("after_abort_data", dr_readdata, 32'h5A5A_5A5A);
        state = 3'd0;
        tick();

        // Reset during WAIT.
        state = 3'd3; mem_waitrequest = 1'b1; mem_readdata = 32'h1357_9BDF;
        tick();
        tick();
        check("rstwait_stall", {31'h0, stall}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstwait_data", dr_readdata, 32'h0);
        check("rstwait_valid", {31'h0, dr_valid}, 32'h0);
        state = 3'd0;
        #1;
        check("rstwait_stall_off", {31'h0, stall}, 32'h0);
        tick();
        state = 3'd3; mem_waitrequest = 1'b0; mem_readdata = 32'hCAFE_F00D;
        tick();
        check("rstwait_recap_valid", {31'h0, dr_valid}, 32'h1);
        check("rstwait_recap_data", dr_readdata, 32'hCAFE_F00D);
        state = 3'd0;
        tick();

        // Reset wins over a capture on the same edge.
        state = 3'd3; mem_readdata = 32'h2468_ACE0; reset = 1'b1;
        tick();
        reset = 1'b0; state = 3'd0;
        check("rstcap_data", dr_readdata, 32'h0);
        check("rstcap_valid", {31'h0, dr_valid}, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d of %0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
